// File: rtl/scanline_gen.sv
// rtl/scanline_gen.sv - line/column scanline darkening stage with 3-clock aligned sync/DE/position delay
module scanline_gen #(
    parameter int LATENCY = 3
) (
    input  logic        PCLK_i,
    input  logic        reset_n,
    input  logic [7:0]  R_i,
    input  logic [7:0]  G_i,
    input  logic [7:0]  B_i,
    input  logic        HSYNC_i,
    input  logic        VSYNC_i,
    input  logic        DE_i,
    input  logic [10:0] xpos_i,
    input  logic [10:0] ypos_i,
    input  logic [31:0] sl_config,
    input  logic [31:0] sl_config2,
    output logic [7:0]  R_o,
    output logic [7:0]  G_o,
    output logic [7:0]  B_o,
    output logic        HSYNC_o,
    output logic        VSYNC_o,
    output logic        DE_o,
    output logic [10:0] xpos_o,
    output logic [10:0] ypos_o
);

    if (LATENCY != 3) begin : g_bad_latency
        $error("scanline_gen only supports LATENCY = 3");
    end

    // Shadow copies of the configuration; only these drive the processing.
    logic [31:0] sh_cfg;
    logic [5:0]  sh_cfg2;

    // Reserved configuration bits are intentionally ignored.
    logic unused_cfg2;
    assign unused_cfg2 = ^sl_config2[31:6];

    logic       c_en, l_en;
    logic [2:0] c_size, l_size, c_offset, l_offset;
    logic [7:0] c_mask, l_mask;
    logic [3:0] c_str, l_str;

    assign c_en     = sh_cfg[31];
    assign l_en     = sh_cfg[30];
    assign c_size   = sh_cfg[29:27];
    assign l_size   = sh_cfg[26:24];
    assign c_mask   = sh_cfg[23:16];
    assign l_mask   = sh_cfg[15:8];
    assign c_str    = sh_cfg[7:4];
    assign l_str    = sh_cfg[3:0];
    assign c_offset = sh_cfg2[5:3];
    assign l_offset = sh_cfg2[2:0];

    // Stage 1 registers; s1_de and s1_vs double as the previous-cycle DE/VSYNC.
    logic [7:0]  s1_r, s1_g, s1_b;
    logic        s1_hs, s1_vs, s1_de;
    logic [10:0] s1_x, s1_y;
    logic [2:0]  s1_lph, s1_cph;

    // Stage 2 registers.
    logic [7:0]  s2_r, s2_g, s2_b;
    logic [7:0]  s2_pr, s2_pg, s2_pb;
    logic        s2_act;
    logic        s2_hs, s2_vs, s2_de;
    logic [10:0] s2_x, s2_y;

    logic line_start;
    assign line_start = DE_i & ~s1_de;

    // Wrapping phase step; a phase above the size is used once then wraps to 0.
    function automatic logic [2:0] inc(input logic [2:0] v, input logic [2:0] s);
        return (v >= s) ? 3'd0 : v + 3'd1;
    endfunction

    // v * (a + 1) / 16; never exceeds v, so the 8-bit result is exact.
    function automatic logic [7:0] shade(input logic [7:0] v, input logic [3:0] a);
        return 8'(({5'd0, v} * {9'd0, a} + {5'd0, v}) >> 4);
    endfunction

    // Latch new configuration on the VSYNC falling edge only, so frames never tear.
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            sh_cfg  <= 32'd0;
            sh_cfg2 <= 6'd0;
        end else if (!VSYNC_i && s1_vs) begin
            sh_cfg  <= sl_config;
            sh_cfg2 <= sl_config2[5:0];
        end
    end

    // Stage 1: capture inputs and advance the line/column phase counters.
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            s1_r   <= 8'd0;
            s1_g   <= 8'd0;
            s1_b   <= 8'd0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_de  <= 1'b0;
            s1_x   <= 11'd0;
            s1_y   <= 11'd0;
            s1_lph <= 3'd0;
            s1_cph <= 3'd0;
        end else begin
            s1_r  <= R_i;
            s1_g  <= G_i;
            s1_b  <= B_i;
            s1_hs <= HSYNC_i;
            s1_vs <= VSYNC_i;
            s1_de <= DE_i;
            s1_x  <= xpos_i;
            s1_y  <= ypos_i;
            if (line_start) begin
                s1_lph <= (ypos_i == 11'd0) ? l_offset : inc(s1_lph, l_size);
                s1_cph <= c_offset;
            end else if (DE_i) begin
                s1_cph <= inc(s1_cph, c_size);
            end
        end
    end

    logic       l_hit, c_hit;
    logic [3:0] l_a, c_a, str_a;

    // Stage 2 combinational: pick the stronger of the two active darkening strengths.
    always_comb begin
        l_hit = l_en & l_mask[s1_lph];
        c_hit = c_en & c_mask[s1_cph];
        l_a   = l_hit ? l_str : 4'd0;
        c_a   = c_hit ? c_str : 4'd0;
        str_a = (l_a > c_a) ? l_a : c_a;
    end

    // Stage 2: register the scaled darkening amount per component.
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            s2_r   <= 8'd0;
            s2_g   <= 8'd0;
            s2_b   <= 8'd0;
            s2_pr  <= 8'd0;
            s2_pg  <= 8'd0;
            s2_pb  <= 8'd0;
            s2_act <= 1'b0;
            s2_hs  <= 1'b1;
            s2_vs  <= 1'b1;
            s2_de  <= 1'b0;
            s2_x   <= 11'd0;
            s2_y   <= 11'd0;
        end else begin
            s2_r   <= s1_r;
            s2_g   <= s1_g;
            s2_b   <= s1_b;
            s2_pr  <= shade(s1_r, str_a);
            s2_pg  <= shade(s1_g, str_a);
            s2_pb  <= shade(s1_b, str_a);
            s2_act <= l_hit | c_hit;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_de  <= s1_de;
            s2_x   <= s1_x;
            s2_y   <= s1_y;
        end
    end

    // Stage 3: subtract the darkening amount and blank pixels outside DE.
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            R_o     <= 8'd0;
            G_o     <= 8'd0;
            B_o     <= 8'd0;
            HSYNC_o <= 1'b1;
            VSYNC_o <= 1'b1;
            DE_o    <= 1'b0;
            xpos_o  <= 11'd0;
            ypos_o  <= 11'd0;
        end else begin
            R_o     <= !s2_de ? 8'd0 : (s2_act ? s2_r - s2_pr : s2_r);
            G_o     <= !s2_de ? 8'd0 : (s2_act ? s2_g - s2_pg : s2_g);
            B_o     <= !s2_de ? 8'd0 : (s2_act ? s2_b - s2_pb : s2_b);
            HSYNC_o <= s2_hs;
            VSYNC_o <= s2_vs;
            DE_o    <= s2_de;
            xpos_o  <= s2_x;
            ypos_o  <= s2_y;
        end
    end

endmodule

// File: tb/tb_scanline_gen.sv
// tb/tb_scanline_gen.sv - scoreboard bench for scanline_gen
module tb_scanline_gen;

    logic        PCLK_i = 1'b0;
    logic        reset_n;
    logic [7:0]  R_i, G_i, B_i;
    logic        HSYNC_i, VSYNC_i, DE_i;
    logic [10:0] xpos_i, ypos_i;
    logic [31:0] sl_config, sl_config2;
    logic [7:0]  R_o, G_o, B_o;
    logic        HSYNC_o, VSYNC_o, DE_o;
    logic [10:0] xpos_o, ypos_o;

    scanline_gen #(.LATENCY(3)) dut (
        .PCLK_i(PCLK_i), .reset_n(reset_n),
        .R_i(R_i), .G_i(G_i), .B_i(B_i),
        .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
        .xpos_i(xpos_i), .ypos_i(ypos_i),
        .sl_config(sl_config), .sl_config2(sl_config2),
        .R_o(R_o), .G_o(G_o), .B_o(B_o),
        .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o),
        .xpos_o(xpos_o), .ypos_o(ypos_o)
    );

    always #5 PCLK_i = ~PCLK_i;

    typedef struct {
        int          tag;
        logic [7:0]  r, g, b;
        logic        hs, vs, de;
        logic [10:0] x, y;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge PCLK_i) cyc = cyc + 1;

    // Pop and compare the entry whose due cycle has arrived.
    always @(negedge PCLK_i) begin
        exp_t e;
        while (q.size() > 0 && q[0].tag < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL sb_missed tag=%0d now=%0d", e.tag, cyc);
        end
        if (q.size() > 0 && q[0].tag == cyc) begin
            e = q.pop_front();
            checks++;
            if ({R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, xpos_o, ypos_o} !==
                {e.r, e.g, e.b, e.hs, e.vs, e.de, e.x, e.y}) begin
                errors++;
                $display("FAIL sb_pixel cyc=%0d got rgb=%h%h%h hs=%b vs=%b de=%b x=%0d y=%0d exp rgb=%h%h%h hs=%b vs=%b de=%b x=%0d y=%0d",
                         cyc, R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, xpos_o, ypos_o,
                         e.r, e.g, e.b, e.hs, e.vs, e.de, e.x, e.y);
            end
        end
    end

    function automatic logic [7:0] dark(input logic [7:0] v, input bit act, input int a);
        int p;
        if (!act) return v;
        p = int'(v) * (a + 1) / 16;
        return 8'(int'(v) - p);
    endfunction

    task automatic drive(input logic [7:0] r, g, b, input logic hs, vs, de,
                         input logic [10:0] x, y, input logic [7:0] er, eg, eb);
        exp_t e;
        R_i = r; G_i = g; B_i = b;
        HSYNC_i = hs; VSYNC_i = vs; DE_i = de;
        xpos_i = x; ypos_i = y;
        e.tag = cyc + 3;
        e.r = er; e.g = eg; e.b = eb;
        e.hs = hs; e.vs = vs; e.de = de; e.x = x; e.y = y;
        q.push_back(e);
        @(posedge PCLK_i);
        #1;
    endtask

    task automatic blank(input int n, input logic hs, vs, input logic [10:0] y);
        for (int i = 0; i < n; i++)
            drive(8'h5A, 8'hA5, 8'h3C, hs, vs, 1'b0, 11'd0, y, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic vframe(input logic [31:0] c1, c2);
        sl_config = c1;
        sl_config2 = c2;
        blank(2, 1'b1, 1'b1, 11'd0);
        blank(2, 1'b1, 1'b0, 11'd0);
        blank(2, 1'b1, 1'b1, 11'd0);
    endtask

    // Columns hit on x%3==1 when cpat is set (C_SIZE=2, C_MASK=0x04, C_OFFSET=1).
    task automatic do_line(input logic [10:0] y, input int w, input logic [7:0] val,
                           input bit lhit, input int lstr, input bit cpat, input int cstr);
        logic [7:0] g, b;
        bit chit, act;
        int a;
        blank(1, 1'b0, 1'b1, y);
        blank(1, 1'b1, 1'b1, y);
        for (int x = 0; x < w; x++) begin
            chit = cpat && (x % 3 == 1);
            a = 0;
            if (lhit && lstr > a) a = lstr;
            if (chit && cstr > a) a = cstr;
            act = lhit | chit;
            g = val ^ 8'(x * 17);
            b = ~val;
            drive(val, g, b, 1'b1, 1'b1, 1'b1, 11'(x), y,
                  dark(val, act, a), dark(g, act, a), dark(b, act, a));
        end
        blank(1, 1'b1, 1'b1, y);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        R_i = 8'hFF; G_i = 8'hFF; B_i = 8'hFF;
        HSYNC_i = 1'b0; VSYNC_i = 1'b1; DE_i = 1'b1;
        xpos_i = 11'd5; ypos_i = 11'd7;
        sl_config = 32'hFFFF_FFFF; sl_config2 = 32'hFFFF_FFFF;
        q.delete();
        for (int i = 0; i < 5; i++) begin
            @(posedge PCLK_i);
            #1;
            checks++;
            if ({R_o, G_o, B_o} !== 24'd0) begin
                errors++; $display("FAIL reset_rgb got %h exp 000000", {R_o, G_o, B_o});
            end
            checks++;
            if (DE_o !== 1'b0) begin errors++; $display("FAIL reset_de got %b exp 0", DE_o); end
            checks++;
            if ({HSYNC_o, VSYNC_o} !== 2'b11) begin
                errors++; $display("FAIL reset_sync got %b exp 11", {HSYNC_o, VSYNC_o});
            end
            checks++;
            if ({xpos_o, ypos_o} !== 22'd0) begin
                errors++; $display("FAIL reset_pos got %0d/%0d exp 0/0", xpos_o, ypos_o);
            end
        end
        sl_config = 32'd0; sl_config2 = 32'd0;
        reset_n = 1'b1;
        do_line(11'd0, 4, 8'h80, 1'b0, 0, 1'b0, 0);
        do_line(11'd1, 3, 8'hC3, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_line;
        vframe(32'h4100_020F, 32'd0);
        for (int y = 0; y < 6; y++)
            do_line(11'(y), 4, 8'hE7, (y % 2) == 1, 15, 1'b0, 0);
        vframe(32'h4100_0207, 32'd0);
        do_line(11'd0, 3, 8'hFF, 1'b0, 7, 1'b0, 0);
        do_line(11'd1, 3, 8'hFF, 1'b1, 7, 1'b0, 0);
    endtask

    task automatic test_column;
        vframe(32'h9004_00F0, 32'h0000_0008);
        for (int y = 0; y < 3; y++)
            do_line(11'(y), 8, 8'h9B, 1'b0, 0, 1'b1, 15);
    endtask

    task automatic test_both;
        vframe(32'hD104_02B3, 32'h0000_0008);
        for (int y = 0; y < 4; y++)
            do_line(11'(y), 7, 8'h40, (y % 2) == 1, 3, 1'b1, 11);
    endtask

    task automatic test_shadow;
        sl_config = 32'd0; sl_config2 = 32'd0;
        do_line(11'd4, 6, 8'h40, 1'b0, 3, 1'b1, 11);
        do_line(11'd5, 6, 8'h40, 1'b1, 3, 1'b1, 11);
        vframe(32'd0, 32'd0);
        do_line(11'd0, 5, 8'h40, 1'b0, 0, 1'b0, 0);
        do_line(11'd1, 5, 8'h40, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_reset_midline;
        vframe(32'h4100_020F, 32'd0);
        do_line(11'd0, 3, 8'h77, 1'b0, 15, 1'b0, 0);
        blank(1, 1'b1, 1'b1, 11'd1);
        drive(8'h66, 8'h66, 8'h66, 1'b1, 1'b1, 1'b1, 11'd0, 11'd1, 8'd0, 8'd0, 8'd0);
        reset_n = 1'b0;
        q.delete();
        @(posedge PCLK_i);
        #1;
        checks++;
        if ({R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, xpos_o, ypos_o} !== {24'd0, 3'b110, 22'd0}) begin
            errors++;
            $display("FAIL midline_reset got rgb=%h hs=%b vs=%b de=%b x=%0d y=%0d exp rgb=000000 hs=1 vs=1 de=0 x=0 y=0",
                     {R_o, G_o, B_o}, HSYNC_o, VSYNC_o, DE_o, xpos_o, ypos_o);
        end
        reset_n = 1'b1;
        do_line(11'd1, 4, 8'hF0, 1'b0, 0, 1'b0, 0);
        do_line(11'd2, 4, 8'h11, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_offset;
        for (int f = 0; f < 2; f++) begin
            vframe(32'h4100_200F, 32'h0000_0005);
            for (int y = 0; y < 5; y++)
                do_line(11'(y), 3, 8'hD2, y == 0, 15, 1'b0, 0);
        end
    endtask

    task automatic test_drain;
        DE_i = 1'b0; HSYNC_i = 1'b1; VSYNC_i = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge PCLK_i);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending exp 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_column();
        test_both();
        test_shadow();
        test_reset_midline();
        test_offset();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
